// File: rtl/ready_pkg.sv
// Shared definitions for the PC/XT bus READY generation blocks:
// wait-state FSM encoding and default timing constants.
package ready_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_FIXED   = 2'd1,
    WAIT_CHANNEL = 2'd2,
    DONE         = 2'd3
  } ready_state_t;

  localparam int unsigned DEFAULT_IO_WAIT_STATES  = 1;
  localparam int unsigned DEFAULT_MEM_WAIT_STATES = 0;
  localparam int unsigned DEFAULT_DMA_CHANNELS    = 4;
  localparam int unsigned DEFAULT_CNT_WIDTH       = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 255;

  function automatic logic is_wait_state(input ready_state_t s);
    return (s == WAIT_FIXED) || (s == WAIT_CHANNEL);
  endfunction

endpackage

// File: rtl/cpu_clock_edge.sv
// Samples the CPU clock level in the fast clock domain and flags its
// rising and falling edges for one fast clock each.
module cpu_clock_edge (
  input  logic clock,
  input  logic reset,
  input  logic cpu_clock,
  output logic cpu_pos,
  output logic cpu_neg
);

  logic prev_cpu_clock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_cpu_clock <= 1'b0;
    else       prev_cpu_clock <= cpu_clock;
  end

  assign cpu_pos = ~prev_cpu_clock & cpu_clock;
  assign cpu_neg = prev_cpu_clock & ~cpu_clock;

endmodule

// File: rtl/ready_wait_gen.sv
// PC/XT bus READY generator: programmable I/O and memory wait states,
// channel-ready extension and a CPU-clock bounded stall timeout.
module ready_wait_gen
  import ready_pkg::*;
#(
  parameter int unsigned IO_WAIT_STATES  = DEFAULT_IO_WAIT_STATES,
  parameter int unsigned MEM_WAIT_STATES = DEFAULT_MEM_WAIT_STATES,
  parameter int unsigned DMA_CHANNELS    = DEFAULT_DMA_CHANNELS,
  parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_clock,
  input  logic                    io_read_n,
  input  logic                    io_write_n,
  input  logic                    memory_read_n,
  input  logic                    address_enable_n,
  input  logic [DMA_CHANNELS-1:0] dma_acknowledge_n,
  input  logic                    dma_wait_n,
  input  logic                    io_channel_ready,
  input  logic                    timeout_clear,
  output logic                    processor_ready,
  output logic                    dma_ready,
  output logic                    bus_timeout,
  output logic                    timeout_status,
  output logic [CNT_WIDTH-1:0]    wait_count
);

  localparam logic [CNT_WIDTH-1:0] IO_N     = CNT_WIDTH'(IO_WAIT_STATES);
  localparam logic [CNT_WIDTH-1:0] MEM_N    = CNT_WIDTH'(MEM_WAIT_STATES);
  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  ready_state_t         state;
  logic                 cpu_pos;
  logic                 cpu_neg;
  logic                 is_io;
  logic                 is_mem;
  logic                 bus_state;
  logic                 prev_bus_state;
  logic                 start;
  logic                 wait_active;
  logic                 ready_ff1;
  logic [CNT_WIDTH-1:0] load_n;
  logic [CNT_WIDTH-1:0] timeout_count;
  logic [CNT_WIDTH-1:0] timeout_next;

  cpu_clock_edge u_cpu_edge (
    .clock     (clock),
    .reset     (reset),
    .cpu_clock (cpu_clock),
    .cpu_pos   (cpu_pos),
    .cpu_neg   (cpu_neg)
  );

  assign is_io        = ~io_read_n | ~io_write_n;
  assign is_mem       = (&dma_acknowledge_n) & ~memory_read_n & address_enable_n;
  assign bus_state    = is_io | is_mem;
  assign start        = bus_state & ~prev_bus_state;
  assign wait_active  = is_wait_state(state);
  assign load_n       = is_io ? IO_N : MEM_N;
  assign timeout_next = timeout_count + CNT_WIDTH'(1);

  // timeout_status set is written after the clear so it wins in the same clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_count     <= '0;
      timeout_count  <= '0;
      bus_timeout    <= 1'b0;
      timeout_status <= 1'b0;
      prev_bus_state <= 1'b1;
    end else begin
      prev_bus_state <= bus_state;
      bus_timeout    <= 1'b0;
      if (timeout_clear) timeout_status <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            timeout_count <= '0;
            if (load_n != '0) begin
              state      <= WAIT_FIXED;
              wait_count <= load_n;
            end else begin
              state <= WAIT_CHANNEL;
            end
          end
        end
        WAIT_FIXED: begin
          if (!bus_state) begin
            state      <= IDLE;
            wait_count <= '0;
          end else if (cpu_pos) begin
            if (wait_count == CNT_WIDTH'(1)) begin
              state      <= WAIT_CHANNEL;
              wait_count <= '0;
            end else begin
              wait_count <= wait_count - CNT_WIDTH'(1);
            end
          end
        end
        WAIT_CHANNEL: begin
          if (!bus_state) begin
            state      <= IDLE;
            wait_count <= '0;
          end else if (cpu_pos) begin
            if (io_channel_ready) begin
              state <= DONE;
            end else begin
              timeout_count <= timeout_next;
              if (timeout_next == TO_LIMIT) begin
                state          <= DONE;
                bus_timeout    <= 1'b1;
                timeout_status <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!bus_state) state <= IDLE;
        end
      endcase
    end
  end

  // Two-stage READY: captured on the CPU rising edge, presented on the falling edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_ff1       <= 1'b0;
      processor_ready <= 1'b0;
      dma_ready       <= 1'b0;
    end else begin
      if (cpu_pos) begin
        ready_ff1 <= dma_wait_n & ~wait_active;
        dma_ready <= ~wait_active;
      end
      if (cpu_neg) processor_ready <= ready_ff1 & dma_wait_n & ~wait_active;
    end
  end

endmodule

// File: tb/tb_ready_wait_gen.sv
// Bench for ready_wait_gen: two configurations driven in lockstep, checked
// each clock against a behavioural model plus scenario tables and sequences.
module tb_ready_wait_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_clock;
  logic       io_read_n, io_write_n, memory_read_n, address_enable_n;
  logic [3:0] dma_acknowledge_n;
  logic       dma_wait_n, io_channel_ready, timeout_clear;
  logic [1:0] pr, dr, bt, ts;
  logic [7:0] wc_a, wc_b;

  ready_wait_gen dut_a (
    .clock(clock), .reset(reset), .cpu_clock(cpu_clock),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .memory_read_n(memory_read_n),
    .address_enable_n(address_enable_n), .dma_acknowledge_n(dma_acknowledge_n),
    .dma_wait_n(dma_wait_n), .io_channel_ready(io_channel_ready),
    .timeout_clear(timeout_clear), .processor_ready(pr[0]), .dma_ready(dr[0]),
    .bus_timeout(bt[0]), .timeout_status(ts[0]), .wait_count(wc_a)
  );

  ready_wait_gen #(.IO_WAIT_STATES(3), .TIMEOUT_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .cpu_clock(cpu_clock),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .memory_read_n(memory_read_n),
    .address_enable_n(address_enable_n), .dma_acknowledge_n(dma_acknowledge_n),
    .dma_wait_n(dma_wait_n), .io_channel_ready(io_channel_ready),
    .timeout_clear(timeout_clear), .processor_ready(pr[1]), .dma_ready(dr[1]),
    .bus_timeout(bt[1]), .timeout_status(ts[1]), .wait_count(wc_b)
  );

  always #5 clock = ~clock;

  int io_ws  [2] = '{1, 3};
  int to_lim [2] = '{255, 4};

  // Behavioural model: remaining fixed waits, channel phase, completion hold
  int m_fixed [2], m_stalls [2];
  bit m_chan [2], m_held [2], m_p1 [2], m_pr [2], m_dr [2], m_bt [2], m_ts [2];
  bit m_pbus [2], m_pc [2];

  bit       s_reset, s_cpu, s_io_read_n, s_io_write_n, s_mem_n, s_aen, s_dwn, s_chan, s_clear;
  bit [3:0] s_ack;
  bit       cpu_auto;
  int       ph;
  int       checks = 0, errors = 0;
  bit       counting;
  int       cnt_dl [2], cnt_pl [2], cnt_bt [2], cnt_ts [2], cnt_tsbt [2];

  typedef struct {
    int kind;
    int stall;
    int k_a;
    int k_b;
    int to_a;
    int to_b;
  } vec_t;
  vec_t tbl [9];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit io, mem, bus, cpos, cneg, busy;
      io   = !io_read_n || !io_write_n;
      mem  = (&dma_acknowledge_n) && !memory_read_n && address_enable_n;
      bus  = io || mem;
      cpos = cpu_clock && !m_pc[k];
      cneg = !cpu_clock && m_pc[k];
      busy = (m_fixed[k] > 0) || m_chan[k];
      if (reset) begin
        m_fixed[k] = 0; m_stalls[k] = 0; m_chan[k] = 0; m_held[k] = 0;
        m_p1[k] = 0; m_pr[k] = 0; m_dr[k] = 0; m_bt[k] = 0; m_ts[k] = 0;
        m_pbus[k] = 1; m_pc[k] = 0;
      end else begin
        if (cneg) m_pr[k] = m_p1[k] && dma_wait_n && !busy;
        if (cpos) begin
          m_p1[k] = dma_wait_n && !busy;
          m_dr[k] = !busy;
        end
        m_bt[k] = 0;
        if (timeout_clear) m_ts[k] = 0;
        if (busy && !bus) begin
          m_fixed[k] = 0;
          m_chan[k]  = 0;
        end else if (m_fixed[k] > 0) begin
          if (cpos) begin
            m_fixed[k]--;
            if (m_fixed[k] == 0) m_chan[k] = 1;
          end
        end else if (m_chan[k]) begin
          if (cpos) begin
            if (io_channel_ready) begin
              m_chan[k] = 0; m_held[k] = 1;
            end else begin
              m_stalls[k]++;
              if (m_stalls[k] == to_lim[k]) begin
                m_chan[k] = 0; m_held[k] = 1; m_bt[k] = 1; m_ts[k] = 1;
              end
            end
          end
        end else if (m_held[k]) begin
          if (!bus) m_held[k] = 0;
        end else if (bus && !m_pbus[k]) begin
          m_stalls[k] = 0;
          if (io && io_ws[k] > 0) m_fixed[k] = io_ws[k];
          else                    m_chan[k]  = 1;
        end
        m_pbus[k] = bus;
        m_pc[k]   = cpu_clock;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [11:0] got, exp;
      got = {pr[k], dr[k], bt[k], ts[k], (k == 0) ? wc_a : wc_b};
      exp = {m_pr[k], m_dr[k], m_bt[k], m_ts[k], 8'(m_fixed[k])};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp inst=%0d t=%0t got=%h expected=%h (pr,dr,bt,ts,wc)", k, $time, got, exp);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    compare_all();
    if (counting) begin
      for (int k = 0; k < 2; k++) begin
        cnt_dl[k]   += int'(!dr[k]);
        cnt_pl[k]   += int'(!pr[k]);
        cnt_bt[k]   += int'(bt[k]);
        cnt_ts[k]   += int'(ts[k]);
        cnt_tsbt[k] += int'(ts[k] & bt[k]);
      end
    end
    reset             = s_reset;
    cpu_clock         = cpu_auto ? ((ph % 4) < 2) : s_cpu;
    io_read_n         = s_io_read_n;
    io_write_n        = s_io_write_n;
    memory_read_n     = s_mem_n;
    address_enable_n  = s_aen;
    dma_acknowledge_n = s_ack;
    dma_wait_n        = s_dwn;
    io_channel_ready  = s_chan;
    timeout_clear     = s_clear;
    model_step();
    ph++;
  endtask

  task automatic idle_stim();
    s_io_read_n = 1; s_io_write_n = 1; s_mem_n = 1; s_aen = 1; s_ack = 4'hF; s_chan = 1;
  endtask

  // One bus cycle starting on a CPU falling edge, held 12 CPU clocks.
  // Channel ready is low at the CPU rising edges 1..stall after the start.
  task automatic run_entry(input int kind, input int stall, input bit clr_hold);
    int c0, kk;
    idle_stim();
    s_clear = 1;
    repeat (8) cycle();
    s_clear = clr_hold;
    while (ph % 4 != 2) cycle();
    c0 = ph / 4;
    case (kind)
      0: s_io_read_n = 0;
      1: s_io_write_n = 0;
      2: s_mem_n = 0;
      3: begin s_mem_n = 0; s_ack = 4'b1011; end
      4: begin s_io_read_n = 0; s_mem_n = 0; end
      default: begin s_mem_n = 0; s_aen = 0; end
    endcase
    for (int k = 0; k < 2; k++) begin
      cnt_dl[k] = 0; cnt_pl[k] = 0; cnt_bt[k] = 0; cnt_ts[k] = 0; cnt_tsbt[k] = 0;
    end
    for (int i = 0; i < 48; i++) begin
      kk = ph / 4 - c0;
      s_chan = !(kk >= 1 && kk <= stall);
      cycle();
      if (i == 0) counting = 1;
    end
    idle_stim();
    repeat (16) cycle();
    counting = 0;
  endtask

  initial begin
    logic [31:0] r;
    tbl[0] = '{0, 0,  2, 4, 0, 0};
    tbl[1] = '{1, 5,  6, 6, 0, 0};
    tbl[2] = '{0, 10, 11, 7, 0, 1};
    tbl[3] = '{2, 0,  1, 1, 0, 0};
    tbl[4] = '{2, 3,  4, 4, 0, 0};
    tbl[5] = '{2, 4,  5, 4, 0, 1};
    tbl[6] = '{3, 0,  0, 0, 0, 0};
    tbl[7] = '{4, 0,  2, 4, 0, 0};
    tbl[8] = '{5, 0,  0, 0, 0, 0};

    counting = 0; cpu_auto = 1; ph = 0;
    s_reset = 1; s_cpu = 0; s_dwn = 1; s_clear = 0;
    idle_stim();
    reset = 1; cpu_clock = 0; io_read_n = 1; io_write_n = 1; memory_read_n = 1;
    address_enable_n = 1; dma_acknowledge_n = 4'hF; dma_wait_n = 1;
    io_channel_ready = 1; timeout_clear = 0;
    model_step();

    cycle();
    check("reset_outputs_a", int'({pr[0], dr[0], bt[0], ts[0]}), 0);
    check("reset_outputs_b", int'({pr[1], dr[1], bt[1], ts[1]}), 0);
    check("reset_wait_count", int'(wc_a) + int'(wc_b), 0);
    repeat (2) cycle();
    s_reset = 0;
    repeat (16) cycle();

    foreach (tbl[i]) begin
      run_entry(tbl[i].kind, tbl[i].stall, 1'b0);
      check($sformatf("tbl%0d_dma_low_a", i),   cnt_dl[0], 4 * tbl[i].k_a);
      check($sformatf("tbl%0d_dma_low_b", i),   cnt_dl[1], 4 * tbl[i].k_b);
      check($sformatf("tbl%0d_ready_low_a", i), cnt_pl[0], 4 * tbl[i].k_a);
      check($sformatf("tbl%0d_ready_low_b", i), cnt_pl[1], 4 * tbl[i].k_b);
      check($sformatf("tbl%0d_timeouts_a", i),  cnt_bt[0], tbl[i].to_a);
      check($sformatf("tbl%0d_timeouts_b", i),  cnt_bt[1], tbl[i].to_b);
      check($sformatf("tbl%0d_status_a", i),    int'(ts[0]), tbl[i].to_a);
      check($sformatf("tbl%0d_status_b", i),    int'(ts[1]), tbl[i].to_b);
    end

    // Clear held throughout: the status may only show on the set clock itself
    run_entry(2, 20, 1'b1);
    check("set_beats_clear_b", cnt_tsbt[1], 1);
    check("status_one_clock_b", cnt_ts[1], 1);
    check("status_never_a", cnt_ts[0], 0);
    s_clear = 0;

    // Reset in the middle of a 3-wait-state I/O cycle, then a fresh cycle
    while (ph % 4 != 2) cycle();
    s_io_read_n = 0;
    repeat (4) cycle();
    check("midcycle_wait_count_b", int'(wc_b), 2);
    s_reset = 1;
    idle_stim();
    cycle();
    #1;
    check("async_reset_flags", int'({pr, dr, bt, ts}), 0);
    check("async_reset_wait_count", int'(wc_a) + int'(wc_b), 0);
    repeat (2) cycle();
    s_reset = 0;
    repeat (12) cycle();
    while (ph % 4 != 2) cycle();
    s_io_read_n = 0;
    cycle();
    @(posedge clock); #1;
    check("reload_wait_count_b", int'(wc_b), 3);
    check("reload_wait_count_a", int'(wc_a), 1);
    idle_stim();
    repeat (60) cycle();

    // dma_wait_n on an idle bus
    while (ph % 4 != 1) cycle();
    s_dwn = 0;
    cycle();
    @(posedge clock); #1;
    check("dma_wait_before_neg", int'(pr), 3);
    cycle();
    @(posedge clock); #1;
    check("dma_wait_after_neg", int'(pr), 0);
    repeat (12) cycle();
    check("dma_wait_dma_ready", int'(dr), 3);
    s_dwn = 1;
    repeat (12) cycle();
    check("dma_wait_release", int'(pr), 3);

    // Randomised traffic against the model
    cpu_auto = 0;
    s_cpu = cpu_clock;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) s_cpu = !s_cpu;
      if ($urandom_range(11) == 0) begin
        r = $urandom;
        s_io_read_n  = r[0] | r[1];
        s_io_write_n = r[2] | r[3] | r[4];
        s_mem_n      = r[5];
        s_aen        = r[6] | r[7];
        s_ack        = (r[8] & r[9]) ? ~(4'b0001 << r[11:10]) : 4'hF;
      end
      if ($urandom_range(3) == 0) s_chan = ($urandom_range(9) < 6);
      s_clear = ($urandom_range(24) == 0);
      s_dwn   = ($urandom_range(11) != 0);
      s_reset = ($urandom_range(599) == 0);
      cycle();
    end
    s_reset = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
